cga_text: RTL

Parametrised text-mode video adapter, successor to the fixed 80x25 CGA block. It generates 640x400 VGA timing from `clock_25` and fetches character, attribute and font bytes from the shared 8 KB video RAM. It adds hardware scrolling through a start-address register, a programmable cursor shape, frame-synchronous shadowing of the control inputs, and a frame strobe for the CPU. It sits between the video RAM read port and the DE0 VGA DAC pins.

---
 rtl/cga_text.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cga_text.sv
// Text-mode video adapter: 640x400 timing on clock_25, cell/font fetch from shared video RAM.
// Build option CGA_TEXT_BLINK_EN: attr[7] selects blink instead of bright background.
module cga_text #(
  parameter int COLS         = 80,
  parameter int ROWS         = 25,
  parameter int FONT_H       = 16,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clock_25,
  input  logic        reset_n,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        HS,
  output logic        VS,
  output logic [12:0] address,
  input  logic [7:0]  data,
  input  logic [10:0] start_addr,
  input  logic [10:0] cursor,
  input  logic [3:0]  cursor_start,
  input  logic [3:0]  cursor_end,
  output logic        frame
);

  localparam int         LN_W    = $clog2(FONT_H);
  localparam int         CNT_W   = $clog2(BLINK_FRAMES + 1);
  localparam logic [9:0] TEXT_W  = 10'(COLS * 8);
  localparam logic [8:0] TEXT_H  = 9'(ROWS * FONT_H);
  localparam logic [3:0] LN_MASK = 4'(FONT_H - 1);

  logic [9:0]       x;
  logic [8:0]       y;
  logic             frame_end;
  logic [10:0]      start_addr_s, cursor_s;
  logic [3:0]       cursor_start_s, cursor_end_s;
  logic [CNT_W-1:0] frame_cnt;
  logic             flash;

  assign frame_end = (x == 10'd799) && (y == 9'd448);
  assign HS        = (x < 10'd704);
  assign VS        = (y >= 9'd447);
  assign frame     = (x == 10'd0) && (y == 9'd435);

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (x == 10'd799) begin
      x <= '0;
      y <= (y == 9'd448) ? 9'd0 : y + 9'd1;
    end else begin
      x <= x + 10'd1;
    end
  end

  // Controls are only sampled between frames so a frame is drawn from one consistent set.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      start_addr_s   <= '0;
      cursor_s       <= '0;
      cursor_start_s <= '0;
      cursor_end_s   <= '0;
    end else if (frame_end) begin
      start_addr_s   <= start_addr;
      cursor_s       <= cursor;
      cursor_start_s <= cursor_start;
      cursor_end_s   <= cursor_end;
    end
  end

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      flash     <= 1'b0;
    end else if (frame) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        flash     <= ~flash;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic [9:0]  px, pf;
  logic [8:0]  py;
  logic [3:0]  ln;
  logic [10:0] row_base, id_f;

  // pf leads the displayed pixel by one cell so the fetch completes before the cell is shown.
  assign px       = x - 10'd48;
  assign pf       = x - 10'd40;
  assign py       = y - 9'd35;
  assign ln       = py[3:0] & LN_MASK;
  assign row_base = 11'(py >> LN_W) * 11'(COLS);
  assign id_f     = start_addr_s + row_base + {4'd0, pf[9:3]};

  logic [7:0]  char_q, attr_q, glyph_q, glyph_d, attr_d;
  logic [10:0] id_q, id_d;

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      address <= '0;
      char_q  <= '0;
      attr_q  <= '0;
      glyph_q <= '0;
      id_q    <= '0;
      glyph_d <= '0;
      attr_d  <= '0;
      id_d    <= '0;
    end else begin
      case (pf[2:0])
        3'd0: begin
          address <= {1'b1, id_f, 1'b0};
          id_q    <= id_f;
        end
        3'd1: begin
          char_q     <= data;
          address[0] <= 1'b1;
        end
        3'd2: begin
          attr_q  <= data;
          address <= {1'b0, char_q, ln};
        end
        3'd3: glyph_q <= data;
        3'd7: begin
          glyph_d <= glyph_q;
          attr_d  <= attr_q;
          id_d    <= id_q;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [11:0] palette(input logic [3:0] idx);
    case (idx)
      4'h0: palette = 12'h000;
      4'h1: palette = 12'h00A;
      4'h2: palette = 12'h0A0;
      4'h3: palette = 12'h0AA;
      4'h4: palette = 12'hA00;
      4'h5: palette = 12'hA0A;
      4'h6: palette = 12'hA50;
      4'h7: palette = 12'hAAA;
      4'h8: palette = 12'h555;
      4'h9: palette = 12'h55F;
      4'hA: palette = 12'h5F5;
      4'hB: palette = 12'h5FF;
      4'hC: palette = 12'hF55;
      4'hD: palette = 12'hF5F;
      4'hE: palette = 12'hFF5;
      default: palette = 12'hFFF;
    endcase
  endfunction

  logic        in_text, glyph_on, cursor_on;
  logic [3:0]  bg_idx;
  logic [11:0] color;

  always_comb begin
    in_text   = 1'b0;
    glyph_on  = 1'b0;
    cursor_on = 1'b0;
    bg_idx    = 4'h0;
    color     = 12'h000;
    in_text = (x >= 10'd48) && (x < 10'd688) && (y >= 9'd35) && (y < 9'd435) &&
              (px < TEXT_W) && (py < TEXT_H);
    // A start line after the end line yields an empty range, hiding the cursor.
    cursor_on = flash && (id_d == cursor_s) && (cursor_start_s <= ln) && (ln <= cursor_end_s);
`ifdef CGA_TEXT_BLINK_EN
    bg_idx   = {1'b0, attr_d[6:4]};
    glyph_on = glyph_d[3'd7 - px[2:0]] && !(attr_d[7] && flash);
`else
    bg_idx   = attr_d[7:4];
    glyph_on = glyph_d[3'd7 - px[2:0]];
`endif
    if (in_text) color = palette((glyph_on || cursor_on) ? attr_d[3:0] : bg_idx);
  end

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) {R, G, B} <= '0;
    else          {R, G, B} <= color;
  end

endmodule
